// File: rtl/aes_cipher_ctrl.sv
// rtl/aes_cipher_ctrl.sv - AES-128 encrypt round sequencer with deferred key reload
//
// Purpose: starts round-key expansion in an external key memory, then walks one
// plaintext block through an external combinational round function, one round
// per cycle, and presents the ciphertext over a valid/ready handshake.
//
// Ports:
//   clk_in, rst_n_in                  clock, asynchronous active-low reset
//   key_load_in, key_in               key load request and 128-bit key
//   key_ready_out, key_err_out        round keys valid, sticky expansion timeout
//   km_init_out, km_key_out           expansion start pulse and held key to key memory
//   km_expanded_in                    expansion done pulse from key memory
//   km_round_out, km_key_in           round-key read index and returned round key
//   blk_valid_in, blk_ready_out       plaintext handshake
//   blk_data_in                       plaintext
//   rnd_state_out, rnd_key_out        state and round key into the round function
//   rnd_last_out                      final round flag (no MixColumns)
//   rnd_state_in                      round function result
//   ct_valid_out, ct_ready_in         ciphertext handshake
//   ct_data_out                       ciphertext

module aes_cipher_ctrl #(
    parameter int NUM_ROUNDS  = 10,
    parameter int KEY_TIMEOUT = 16
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         key_load_in,
    input  logic [127:0] key_in,
    output logic         key_ready_out,
    output logic         key_err_out,
    output logic         km_init_out,
    output logic [127:0] km_key_out,
    input  logic         km_expanded_in,
    output logic [3:0]   km_round_out,
    input  logic [127:0] km_key_in,
    input  logic         blk_valid_in,
    output logic         blk_ready_out,
    input  logic [127:0] blk_data_in,
    output logic [127:0] rnd_state_out,
    output logic [127:0] rnd_key_out,
    output logic         rnd_last_out,
    input  logic [127:0] rnd_state_in,
    output logic         ct_valid_out,
    input  logic         ct_ready_in,
    output logic [127:0] ct_data_out
);

    localparam int            TW       = (KEY_TIMEOUT > 2) ? $clog2(KEY_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(KEY_TIMEOUT - 1);
    localparam logic [3:0]    LAST_RND = 4'(NUM_ROUNDS);

    typedef enum logic [2:0] {
        S_NOKEY  = 3'd0,
        S_EXPAND = 3'd1,
        S_IDLE   = 3'd2,
        S_ROUND  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e          fsm_q, fsm_d;
    logic [127:0]    key_q, key_d;
    logic [127:0]    st_q, st_d;
    logic [3:0]      rnd_q, rnd_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            pend_q, pend_d;
    logic            err_q, err_d;
    logic            start_exp;

    logic            init_q;
    logic            key_rdy_q;
    logic            blk_rdy_q;
    logic            ct_vld_q;
    logic            last_q;

    always_comb begin
        fsm_d     = fsm_q;
        key_d     = key_q;
        st_d      = st_q;
        rnd_d     = rnd_q;
        tmo_d     = tmo_q;
        pend_d    = pend_q;
        err_d     = err_q;
        start_exp = 1'b0;

        // A load always replaces the held key and clears a past timeout;
        // whether it restarts expansion now or later depends on the state.
        if (key_load_in) begin
            key_d = key_in;
            err_d = 1'b0;
        end

        case (fsm_q)
            S_NOKEY: begin
                if (key_load_in) begin
                    start_exp = 1'b1;
                end
            end
            S_EXPAND: begin
                if (key_load_in) begin
                    start_exp = 1'b1;
                end else if (km_expanded_in) begin
                    fsm_d = S_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    fsm_d = S_NOKEY;
                    err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_IDLE: begin
                // An accepted block wins over a same-cycle load: it is
                // whitened with the current round key 0 and the reload waits.
                if (blk_valid_in) begin
                    st_d  = blk_data_in ^ km_key_in;
                    rnd_d = 4'd1;
                    fsm_d = S_ROUND;
                    if (key_load_in) begin
                        pend_d = 1'b1;
                    end
                end else if (key_load_in) begin
                    start_exp = 1'b1;
                end
            end
            S_ROUND: begin
                st_d = rnd_state_in;
                if (key_load_in) begin
                    pend_d = 1'b1;
                end
                if (rnd_q == LAST_RND) begin
                    fsm_d = S_DONE;
                    rnd_d = 4'd0;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_DONE: begin
                if (ct_ready_in) begin
                    // A load arriving on the handshake cycle counts as pending.
                    if (pend_q || key_load_in) begin
                        start_exp = 1'b1;
                    end else begin
                        fsm_d = S_IDLE;
                    end
                end else if (key_load_in) begin
                    pend_d = 1'b1;
                end
            end
            default: begin
                fsm_d = S_NOKEY;
            end
        endcase

        if (start_exp) begin
            fsm_d  = S_EXPAND;
            tmo_d  = '0;
            pend_d = 1'b0;
        end
    end

    // Output flags are computed from the next state so they are registered
    // yet line up with the state they describe.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fsm_q     <= S_NOKEY;
            key_q     <= '0;
            st_q      <= '0;
            rnd_q     <= '0;
            tmo_q     <= '0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            init_q    <= 1'b0;
            key_rdy_q <= 1'b0;
            blk_rdy_q <= 1'b0;
            ct_vld_q  <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            key_q     <= key_d;
            st_q      <= st_d;
            rnd_q     <= rnd_d;
            tmo_q     <= tmo_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            init_q    <= start_exp;
            key_rdy_q <= (fsm_d == S_IDLE) || (fsm_d == S_ROUND) || (fsm_d == S_DONE);
            blk_rdy_q <= (fsm_d == S_IDLE);
            ct_vld_q  <= (fsm_d == S_DONE);
            last_q    <= (fsm_d == S_ROUND) && (rnd_d == LAST_RND);
        end
    end

    assign key_ready_out = key_rdy_q;
    assign key_err_out   = err_q;
    assign km_init_out   = init_q;
    assign km_key_out    = key_q;
    assign km_round_out  = rnd_q;
    assign blk_ready_out = blk_rdy_q;
    assign rnd_state_out = st_q;
    assign rnd_key_out   = km_key_in;
    assign rnd_last_out  = last_q;
    assign ct_valid_out  = ct_vld_q;
    assign ct_data_out   = st_q;

endmodule

// File: tb/tb_aes_cipher_ctrl.sv
// tb/tb_aes_cipher_ctrl.sv - self-checking bench for aes_cipher_ctrl

module tb_aes_cipher_ctrl;

    localparam int NR = 10;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK10_K1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic         key_load_in;
    logic [127:0] key_in;
    logic         key_ready_out;
    logic         key_err_out;
    logic         km_init_out;
    logic [127:0] km_key_out;
    logic         km_expanded_in;
    logic [3:0]   km_round_out;
    logic [127:0] km_key_in;
    logic         blk_valid_in;
    logic         blk_ready_out;
    logic [127:0] blk_data_in;
    logic [127:0] rnd_state_out;
    logic [127:0] rnd_key_out;
    logic         rnd_last_out;
    logic [127:0] rnd_state_in;
    logic         ct_valid_out;
    logic         ct_ready_in;
    logic [127:0] ct_data_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    aes_cipher_ctrl #(.NUM_ROUNDS(NR), .KEY_TIMEOUT(16)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .key_load_in   (key_load_in),
        .key_in        (key_in),
        .key_ready_out (key_ready_out),
        .key_err_out   (key_err_out),
        .km_init_out   (km_init_out),
        .km_key_out    (km_key_out),
        .km_expanded_in(km_expanded_in),
        .km_round_out  (km_round_out),
        .km_key_in     (km_key_in),
        .blk_valid_in  (blk_valid_in),
        .blk_ready_out (blk_ready_out),
        .blk_data_in   (blk_data_in),
        .rnd_state_out (rnd_state_out),
        .rnd_key_out   (rnd_key_out),
        .rnd_last_out  (rnd_last_out),
        .rnd_state_in  (rnd_state_in),
        .ct_valid_out  (ct_valid_out),
        .ct_ready_in   (ct_ready_in),
        .ct_data_out   (ct_data_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from its definition: x^254 (GF inverse) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] key, input int n);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127 - 8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c + r] = b[4*((c + r) % 4) + r];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ round_key(key, 0);
        for (int r = 1; r <= NR; r++) s = aes_round(s, round_key(key, r), r == NR);
        return s;
    endfunction

    // ---------------- environment: round function and key memory ----------------
    logic [127:0] rk_mem [0:10];
    bit           km_dead = 1'b0;

    assign rnd_state_in = aes_round(rnd_state_out, rnd_key_out, rnd_last_out);
    assign km_key_in    = (km_round_out <= 4'd10) ? rk_mem[km_round_out] : '0;

    initial begin : key_memory
        int kcnt;
        kcnt = 0;
        km_expanded_in = 1'b0;
        for (int r = 0; r <= NR; r++) rk_mem[r] = '0;
        forever begin
            @(posedge clk_in);
            #1;
            km_expanded_in = 1'b0;
            if (!rst_n_in) begin
                kcnt = 0;
            end else if (km_init_out) begin
                for (int r = 0; r <= NR; r++) rk_mem[r] = round_key(km_key_out, r);
                kcnt = 3;
            end else if (kcnt > 0) begin
                if (kcnt == 1 && !km_dead) km_expanded_in = 1'b1;
                kcnt--;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: expected ciphertexts are full AES encryptions
    // under the key in effect at acceptance; timing expectations are stated
    // as cycle offsets from the accept.
    logic [127:0] exp_q [$];
    int           acc_hist [$];
    int           acc_cyc = -1;
    bit           pend_m = 1'b0;
    int           nxt_expect = 0;
    logic [127:0] active_key = '0;
    logic [127:0] last_loaded = '0;

    always @(negedge clk_in) begin : compare
        int d;
        if (!rst_n_in) begin
            acc_cyc = -1;
            exp_q.delete();
            pend_m = 1'b0;
            nxt_expect = 0;
        end else begin
            if (nxt_expect == 1) chk("ready_after_ct", 128'(blk_ready_out), 128'(1));
            else if (nxt_expect == 2) chk("init_after_ct", 128'(km_init_out), 128'(1));
            nxt_expect = 0;
            if (acc_cyc >= 0) begin
                if (key_load_in) pend_m = 1'b1;
                d = cyc - acc_cyc;
                if (d <= NR) begin
                    chk("round_idx", 128'(km_round_out), 128'(d));
                    chk("round_last", 128'(rnd_last_out), 128'(d == NR));
                    chk("busy_flags", 128'({blk_ready_out, ct_valid_out}), 128'(0));
                end else begin
                    chk("ct_valid", 128'(ct_valid_out), 128'(1));
                    chk("done_no_ready", 128'(blk_ready_out), 128'(0));
                    if (exp_q.size() > 0) chk("ct_data", ct_data_out, exp_q[0]);
                    if (ct_valid_out && ct_ready_in) begin
                        void'(exp_q.pop_front());
                        acc_cyc = -1;
                        nxt_expect = pend_m ? 2 : 1;
                        pend_m = 1'b0;
                    end else if (d > 300) begin
                        chk("ct_handshake_timeout", 128'(0), 128'(1));
                        acc_cyc = -1;
                    end
                end
            end else begin
                chk("idle_ct_valid", 128'(ct_valid_out), 128'(0));
                chk("idle_round_idx", 128'(km_round_out), 128'(0));
                if (blk_valid_in && blk_ready_out) begin
                    acc_cyc = cyc;
                    acc_hist.push_back(cyc);
                    exp_q.push_back(aes_encrypt(active_key, blk_data_in));
                    if (key_load_in) pend_m = 1'b1;
                end
            end
            if (km_expanded_in) active_key = last_loaded;
            if (key_load_in) last_loaded = key_in;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        key_load_in = 1'b1;
        key_in = k;
        tick();
        key_load_in = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] pt);
        int n;
        n = 0;
        blk_valid_in = 1'b1;
        blk_data_in = pt;
        @(negedge clk_in);
        while (!blk_ready_out && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        chk("accept", 128'(blk_ready_out), 128'(1));
        tick();
        blk_valid_in = 1'b0;
    endtask

    task automatic wait_ct(input string name, input logic [127:0] exp);
        int n;
        n = 0;
        @(negedge clk_in);
        while (!ct_valid_out && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        chk({name, "_valid"}, 128'(ct_valid_out), 128'(1));
        chk({name, "_ct"}, ct_data_out, exp);
        tick();
    endtask

    task automatic wait_round(input logic [3:0] idx);
        int n;
        n = 0;
        @(negedge clk_in);
        while (km_round_out != idx && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        chk("wait_round", 128'(km_round_out), 128'(idx));
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_flags"}, 128'({key_ready_out, key_err_out, km_init_out, blk_ready_out,
                                    rnd_last_out, ct_valid_out, km_round_out}), 128'(0));
        chk({name, "_km_key"}, km_key_out, '0);
        chk({name, "_rnd_state"}, rnd_state_out, '0);
        chk({name, "_ct_data"}, ct_data_out, '0);
    endtask

    initial begin : watchdog
        #400000;
        errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin : stimulus
        logic [127:0] hold;
        logic [127:0] b2b [3];
        int n;
        rst_n_in = 1'b0;
        key_load_in = 1'b0;
        key_in = '0;
        blk_valid_in = 1'b0;
        blk_data_in = '0;
        ct_ready_in = 1'b1;

        // Pin the reference model to published vectors.
        chk("model_fips_c1", aes_encrypt(K1, PT1), CT1);
        chk("model_fips_b", aes_encrypt(K2, PT2), CT2);
        chk("model_rk10", round_key(K1, 10), RK10_K1);

        repeat (3) @(negedge clk_in);
        check_all_zero("reset");
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        tick();

        // Key load and FIPS-197 C.1 block
        load_key(K1);
        @(negedge clk_in);
        chk("init_first", 128'(km_init_out), 128'(1));
        @(negedge clk_in);
        chk("init_second", 128'(km_init_out), 128'(0));
        chk("expand_key_ready", 128'(key_ready_out), 128'(0));
        tick();
        send_block(PT1);
        wait_ct("fips", CT1);

        // Back-to-back blocks with the consumer always ready
        b2b[0] = PT2;
        b2b[1] = 128'h0123456789abcdeffedcba9876543210;
        b2b[2] = 128'hffffffffffffffffffffffffffffffff;
        blk_valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            blk_data_in = b2b[i];
            n = 0;
            @(negedge clk_in);
            while (!blk_ready_out && n < 100) begin
                @(negedge clk_in);
                n++;
            end
            chk("b2b_accept", 128'(blk_ready_out), 128'(1));
            tick();
        end
        blk_valid_in = 1'b0;
        wait_ct("b2b", aes_encrypt(K1, b2b[2]));
        n = acc_hist.size();
        chk("b2b_period_a", 128'(acc_hist[n-2] - acc_hist[n-3]), 128'(12));
        chk("b2b_period_b", 128'(acc_hist[n-1] - acc_hist[n-2]), 128'(12));

        // Backpressure: ciphertext held while the consumer stalls
        ct_ready_in = 1'b0;
        send_block(PT2);
        n = 0;
        @(negedge clk_in);
        while (!ct_valid_out && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        hold = ct_data_out;
        chk("bp_ct", hold, aes_encrypt(K1, PT2));
        repeat (5) begin
            @(negedge clk_in);
            chk("bp_stable", ct_data_out, hold);
            chk("bp_flags", 128'({ct_valid_out, blk_ready_out, km_round_out}), 128'({1'b1, 1'b0, 4'd0}));
        end
        tick();
        ct_ready_in = 1'b1;
        tick();

        // Key reload during round 4 is deferred until the ciphertext is taken
        send_block(PT1);
        wait_round(4'd3);
        tick();
        load_key(K2);
        wait_ct("defer_old", CT1);
        @(negedge clk_in);
        chk("defer_init", 128'(km_init_out), 128'(1));
        tick();
        send_block(PT2);
        wait_ct("defer_new", CT2);

        // Same-cycle load and accept in idle: block keeps the old key
        blk_valid_in = 1'b1;
        blk_data_in = PT2;
        key_load_in = 1'b1;
        key_in = K1;
        @(negedge clk_in);
        chk("same_idle_ready", 128'(blk_ready_out), 128'(1));
        tick();
        blk_valid_in = 1'b0;
        key_load_in = 1'b0;
        wait_ct("same_old", CT2);
        @(negedge clk_in);
        chk("same_init", 128'(km_init_out), 128'(1));
        tick();
        send_block(PT1);
        wait_ct("same_new", CT1);

        // Expansion timeout: key memory never answers
        km_dead = 1'b1;
        load_key(K2);
        @(negedge clk_in);
        chk("tmo_init", 128'(km_init_out), 128'(1));
        repeat (15) @(negedge clk_in);
        chk("tmo_err_early", 128'(key_err_out), 128'(0));
        @(negedge clk_in);
        chk("tmo_err", 128'(key_err_out), 128'(1));
        chk("tmo_ready_flags", 128'({key_ready_out, blk_ready_out}), 128'(0));
        tick();
        km_dead = 1'b0;
        load_key(K1);
        @(negedge clk_in);
        chk("tmo_err_clear", 128'(key_err_out), 128'(0));
        tick();
        send_block(PT1);
        wait_ct("tmo_recover", CT1);

        // Asynchronous reset in round 5
        send_block(PT2);
        wait_round(4'd5);
        #2;
        rst_n_in = 1'b0;
        #1;
        check_all_zero("async");
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        repeat (15) @(negedge clk_in);
        chk("ar_after", 128'({key_ready_out, blk_ready_out, ct_valid_out}), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
